uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
// - Serial-to-byte receiver. Directly upstream of byte_sink; feeds it over a valid/ready byte stream.
// - Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous serial line.
// - Presents each good byte on a one-deep registered output. Pulses error flags on framing errors and overruns.
//
// PARAMETERS
// - CLOCKS_PER_BIT  16  _clock cycles per serial bit; must be even and >= 4
// - CNT_W           $clog2(CLOCKS_PER_BIT)  bit-timer width (derived, not overridden)
//
// PORTS
// - _clock      in   1  single clock; all state updates on its rising edge
// - _reset      in   1  synchronous, active-high reset
// - _ser_in     in   1  asynchronous serial line; idles high
// - _out        out  8  received byte
// - _out_valid  out  1  _out holds an unconsumed byte
// - _out_ready  in   1  consumer accepts _out when high and _out_valid is high
// - _busy       out  1  high whenever the receiver is not IDLE
// - _frame_err  out  1  1-cycle pulse: stop bit sampled low
// - _overrun    out  1  1-cycle pulse: new byte dropped because the output was still full
//
// BEHAVIOUR
// - Reset: state IDLE, counters 0, shift register 0, _out=0, _out_valid=0, _busy=0, _frame_err=0, _overrun=0.
//   - Both synchronizer flops reset to 1 (idle line).
//   - Reset asserted mid-frame aborts the frame; no flag pulses on that cycle or the next.
// - Input: _ser_in passes through 2-flop synchronizer -> rx_s. All decisions use rx_s only.
// - FSM, with cnt = bit timer and bit_idx = 0..7:
//   - IDLE:  rx_s==0 -> START, cnt=0.
//   - START: cnt++. At cnt==CLOCKS_PER_BIT/2-1, sample rx_s:
//     - 0 -> DATA, cnt=0, bit_idx=0.
//     - 1 -> glitch; return to IDLE, no flag.
//   - DATA:  cnt++. At cnt==CLOCKS_PER_BIT-1: shreg <= {rx_s, shreg[7:1]} (LSB first), cnt=0.
//     - bit_idx==7 -> STOP; else bit_idx++.
//   - STOP:  cnt++. At cnt==CLOCKS_PER_BIT-1, sample rx_s, then go to IDLE:
//     - 1 -> deliver shreg.
//     - 0 -> _frame_err pulse next cycle; byte discarded.
// - Every sample lands at the bit centre, measured from the synchronized falling edge.
// - Delivery. The output register may load when (!_out_valid) || (_out_valid && _out_ready):
//   - Loadable -> _out<=shreg, _out_valid<=1 on the cycle after the stop sample (1-cycle latency).
//   - Not loadable -> byte dropped; the old _out is kept; _overrun pulses on that same cycle.
// - Handshake rules:
//   - Transfer occurs when _out_valid && _out_ready; with no simultaneous load, _out_valid<=0.
//   - Simultaneous consume and deliver: the new byte loads and _out_valid stays 1 (back-to-back allowed).
//   - _out is stable while _out_valid && !_out_ready.
// - _busy = (state != IDLE), registered with the state.
// - Counters never wrap: cnt clears at each compare point; bit_idx clears on START->DATA.
//
// STRUCTURE
// - uart_pkg: typedef enum logic[1:0] {IDLE, START, DATA, STOP} uart_state_t; constants DATA_BITS=8, STOP_BITS=1.
//   - Shared with the future uart_tx.
// - Sub-module uart_sync: generic 2-flop synchronizer with reset value parameter (RESET_VAL=1 here).
// - Everything else stays in uart_rx: FSM, bit timer, shift register, output register.
//
// TESTING  (CLOCKS_PER_BIT=4, bit period 4 cycles, _out_ready=1 unless stated)
// - Send 0xA5 8N1 -> _out=0xA5, _out_valid=1.
//   - _out_valid rises 1 cycle after the stop-bit centre sample.
//   - _frame_err=0, _overrun=0.
// - Low glitch of 1 cycle on an idle line -> back to IDLE after the START check; no _out_valid, no flags.
// - Send 0x3C with the stop bit forced 0 -> one _frame_err pulse; _out_valid stays 0; next frame 0x81 received correctly.
// - _out_ready=0; send 0x11 then 0x22 -> _out=0x11 held, one _overrun pulse on the 0x22 delivery.
//   - Then _out_ready=1 -> 0x11 consumed, _out_valid=0.
// - Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three valids, in order.
//   - _busy stays high across the frame boundaries, except at least 1 IDLE cycle.
// - Assert _reset for 1 cycle during DATA bit 3 of 0x7E -> all outputs 0.
//   - The next full frame 0x42 is received correctly; no spurious flags.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer with configurable reset value
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic _clock,
    input  logic _reset,
    input  logic _d,
    output logic _q
);
    logic meta;
    always_ff @(posedge _clock) begin
        if (_reset) {meta, _q} <= {2{RESET_VAL}};
        else        {meta, _q} <= {_d, meta};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-deep valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic       _clock,
    input  logic       _reset,
    input  logic       _ser_in,
    output logic [7:0] _out,
    output logic       _out_valid,
    input  logic       _out_ready,
    output logic       _busy,
    output logic       _frame_err,
    output logic       _overrun
);
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_BITS - 1);
    uart_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n;
    logic rx_s, stop_ok, stop_bad;
    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        ._clock(_clock),
        ._reset(_reset),
        ._d    (_ser_in),
        ._q    (rx_s)
    );
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : START;
            end
            START: if (cnt == HALF) begin
                cnt_n     = '0;
                bit_idx_n = '0;
                state_n   = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
                cnt_n     = '0;
                shreg_n   = {rx_s, shreg[7:1]};
                bit_idx_n = (bit_idx == LAST) ? bit_idx : bit_idx + 1'b1;
                state_n   = (bit_idx == LAST) ? STOP : DATA;
            end
            STOP: if (cnt == FULL) begin
                cnt_n    = '0;
                state_n  = IDLE;
                stop_ok  = rx_s;
                stop_bad = !rx_s;
            end
            default: state_n = IDLE;
        endcase
    end
    // A finished byte loads only if the output slot is empty or being drained this cycle.
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            _out       <= '0;
            _out_valid <= 1'b0;
            _busy      <= 1'b0;
            _frame_err <= 1'b0;
            _overrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            _busy      <= state_n != IDLE;
            _frame_err <= stop_bad;
            _overrun   <= stop_ok && _out_valid && !_out_ready;
            if (stop_ok && (!_out_valid || _out_ready)) begin
                _out       <= shreg;
                _out_valid <= 1'b1;
            end else if (_out_ready) begin
                _out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a timestamp-based receiver model
module tb_uart_rx;
    localparam int P = 4;
    localparam int H = P / 2;

    logic clk = 1'b0, rst = 1'b1, ser_in = 1'b1, out_ready = 1'b1;
    logic [7:0] out;
    logic out_valid, busy, frame_err, overrun;

    uart_rx #(.CLOCKS_PER_BIT(P)) dut (
        ._clock    (clk),
        ._reset    (rst),
        ._ser_in   (ser_in),
        ._out      (out),
        ._out_valid(out_valid),
        ._out_ready(out_ready),
        ._busy     (busy),
        ._frame_err(frame_err),
        ._overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Model: line history delayed by the synchronizer; samples placed by arithmetic on the detect time.
    int m_cyc = 0, d = 0;
    bit p1 = 1'b1, p2 = 1'b1, act = 1'b0;
    logic [7:0] acc = '0, m_out = '0;
    bit m_ov = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;

    always @(posedge clk) begin : model
        bit rx, deliver, old;
        int rel, k;
        m_cyc++;
        rx = p2;
        p2 = p1;
        p1 = ser_in;
        deliver = 1'b0;
        if (rst) begin
            p1 = 1'b1; p2 = 1'b1; act = 1'b0; acc = '0;
            m_out = '0; m_ov = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            if (!act) begin
                if (!rx) begin act = 1'b1; d = m_cyc; end
            end else begin
                rel = m_cyc - d;
                if (rel == H) act = !rx;
                else if (rel > H && (rel - H) % P == 0) begin
                    k = (rel - H) / P;
                    if (k <= 8) acc[k-1] = rx;
                    else begin
                        act = 1'b0;
                        deliver = rx;
                        m_ferr = !rx;
                    end
                end
            end
            old = m_ov;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (deliver) begin
                if (!old || out_ready) begin m_out = acc; m_ov = 1'b1; end
                else m_ovr = 1'b1;
            end
        end
        m_busy = act;
    end

    int passed = 0, total = 0, ferr_n = 0, ovr_n = 0;
    bit armed = 1'b0, rand_rdy = 1'b0;
    logic [7:0] rxq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, m_cyc);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("valid", out_valid, m_ov);
            if (m_ov) check("out", out, m_out);
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            check("busy", busy, m_busy);
        end
        if (out_valid && out_ready) rxq.push_back(out);
        ferr_n += frame_err;
        ovr_n += overrun;
    end

    task automatic drive(input bit v);
        ser_in = v;
        if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop, output int k);
        k = m_cyc;
        repeat (P) drive(1'b0);
        for (int i = 0; i < 8; i++) repeat (P) drive(b[i]);
        repeat (P) drive(stop);
        ser_in = 1'b1;
    endtask

    task automatic idle(input int bits);
        @(posedge clk);
        #1;
        repeat (bits * P) drive(1'b1);
    endtask

    task automatic wait_edge(input int n);
        do @(negedge clk); while (m_cyc < n);
    endtask

    initial begin
        int k, k2, k3, f0, o0;
        logic [7:0] b7e;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        idle(2);

        send(8'hA5, 1'b1, k);
        wait_edge(k + 40);
        check("a5_early_valid", out_valid, 0);
        wait_edge(k + 41);
        check("a5_valid", out_valid, 1);
        check("a5_out", out, 8'hA5);
        check("a5_flags", {frame_err, overrun}, 0);

        f0 = ferr_n;
        idle(1);
        drive(1'b0);
        repeat (3 * P) drive(1'b1);
        check("glitch_valid", out_valid, 0);
        check("glitch_busy", busy, 0);
        check("glitch_flags", ferr_n - f0, 0);

        send(8'h3C, 1'b0, k);
        wait_edge(k + 41);
        check("ferr_pulse", frame_err, 1);
        check("ferr_valid", out_valid, 0);
        idle(2);
        send(8'h81, 1'b1, k);
        wait_edge(k + 41);
        check("after_ferr_out", out, 8'h81);
        check("after_ferr_valid", out_valid, 1);

        idle(1);
        rxq.delete();
        o0 = ovr_n;
        out_ready = 1'b0;
        send(8'h11, 1'b1, k);
        send(8'h22, 1'b1, k2);
        wait_edge(k2 + 41);
        check("ovr_pulse", overrun, 1);
        check("ovr_hold_out", out, 8'h11);
        check("ovr_hold_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_drained", out_valid, 0);
        check("ovr_count", ovr_n - o0, 1);
        check("ovr_rx_n", rxq.size(), 1);
        check("ovr_rx0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h11);

        idle(1);
        rxq.delete();
        send(8'h00, 1'b1, k);
        send(8'hFF, 1'b1, k2);
        send(8'h55, 1'b1, k3);
        wait_edge(k3 + 42);
        check("b2b_n", rxq.size(), 3);
        check("b2b_0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h00);
        check("b2b_1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'hFF);
        check("b2b_2", rxq.size() > 2 ? rxq[2] : 8'hxx, 8'h55);

        idle(1);
        rxq.delete();
        f0 = ferr_n;
        o0 = ovr_n;
        b7e = 8'h7E;
        repeat (P) drive(1'b0);
        for (int i = 0; i < 3; i++) repeat (P) drive(b7e[i]);
        repeat (2) drive(b7e[3]);
        rst = 1'b1;
        drive(1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out", out, 8'h00);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_flags", {frame_err, overrun}, 0);
        idle(12);
        send(8'h42, 1'b1, k);
        wait_edge(k + 41);
        check("post_rst_out", out, 8'h42);
        idle(1);
        check("post_rst_n", rxq.size(), 1);
        check("post_rst_flags", (ferr_n - f0) + (ovr_n - o0), 0);

        rand_rdy = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int r;
            bit st;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(1'b0);
                repeat (3 * P) drive(1'b1);
            end else begin
                st = (r != 1);
                send(8'($urandom), st, k);
                repeat ((st ? $urandom_range(0, 2) : $urandom_range(1, 3)) * P) drive(1'b1);
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (15 * P) drive(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
